// File: rtl/ap_handshake_perf_monitor.sv
// Per-channel HLS ap_* handshake tracker with saturating perf counters; readback is 1-cycle registered.
// Purely observational: never drives or backpressures the monitored handshakes; finish freezes all counting.
module ap_handshake_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              clear,
    input  logic              finish,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_err,
    output logic              any_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONES = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // MSB flags an attempted increment past all-ones; the value itself sticks at all-ones.
    function automatic logic [CNT_W:0] f_inc(input logic [CNT_W-1:0] v);
        f_inc = (v == ONES) ? {1'b1, ONES} : {1'b0, v + ONE};
    endfunction

    logic [CNT_W-1:0]  w_fld [NUM_CH][8];
    logic [NUM_CH-1:0] w_busy_vec;
    logic [CNT_W-1:0]  w_rd_data;
    logic              w_rd_err;
    logic              w_unused;

    // ap_ready is observed only; it never gates a start.
    assign w_unused = ^ap_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state, w_next;
        logic [CNT_W-1:0] r_start, r_done, r_busy, r_last, r_max, r_min, r_stall, r_lat;
        logic             r_sat;
        logic             w_start, w_rec, w_lat_set, w_lat_inc, w_busy_inc, w_stall_inc, w_ovf;
        logic [CNT_W:0]   w_s, w_d, w_b, w_st, w_l;
        logic [CNT_W-1:0] w_lat_val;
        logic             w_lat_ovf;

        assign w_s  = f_inc(r_start);
        assign w_d  = f_inc(r_done);
        assign w_b  = f_inc(r_busy);
        assign w_st = f_inc(r_stall);
        assign w_l  = f_inc(r_lat);

        assign w_busy_inc  = (r_state != S_IDLE);
        assign w_stall_inc = (r_state == S_WAIT);
        // A same-cycle start/done/continue in IDLE is a one-cycle transaction.
        assign w_lat_val   = (r_state == S_IDLE) ? ONE : w_l[CNT_W-1:0];
        assign w_lat_ovf   = (r_state != S_IDLE) & w_l[CNT_W];

        always_comb begin
            w_next    = r_state;
            w_start   = 1'b0;
            w_rec     = 1'b0;
            w_lat_set = 1'b0;
            w_lat_inc = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ap_start[g]) begin
                        w_start = 1'b1;
                        if (ap_done[g] && ap_continue[g]) begin
                            w_rec = 1'b1;
                        end else begin
                            w_lat_set = 1'b1;
                            w_next    = ap_done[g] ? S_WAIT : S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (ap_done[g] && ap_continue[g]) begin
                        w_rec  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_lat_inc = 1'b1;
                        if (ap_done[g]) w_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ap_continue[g]) begin
                        w_rec  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_lat_inc = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end

        assign w_ovf = (w_start & w_s[CNT_W]) | (w_rec & w_d[CNT_W]) | (w_busy_inc & w_b[CNT_W])
                     | (w_stall_inc & w_st[CNT_W]) | (w_lat_inc & w_l[CNT_W]) | (w_rec & w_lat_ovf);

        always_ff @(posedge clock) begin
            if (reset || clear) begin
                r_state <= S_IDLE;
                r_start <= '0;
                r_done  <= '0;
                r_busy  <= '0;
                r_last  <= '0;
                r_max   <= '0;
                r_min   <= ONES;
                r_stall <= '0;
                r_lat   <= '0;
                r_sat   <= 1'b0;
            end else if (!finish) begin
                r_state <= w_next;
                r_sat   <= r_sat | w_ovf;
                if (w_start)     r_start <= w_s[CNT_W-1:0];
                if (w_busy_inc)  r_busy  <= w_b[CNT_W-1:0];
                if (w_stall_inc) r_stall <= w_st[CNT_W-1:0];
                if (w_lat_set)   r_lat   <= ONE;
                else if (w_lat_inc) r_lat <= w_l[CNT_W-1:0];
                if (w_rec) begin
                    r_done <= w_d[CNT_W-1:0];
                    r_last <= w_lat_val;
                    if (w_lat_val > r_max) r_max <= w_lat_val;
                    if (w_lat_val < r_min) r_min <= w_lat_val;
                end
            end
        end

        assign w_busy_vec[g] = (r_state != S_IDLE);
        assign w_fld[g][0]   = r_start;
        assign w_fld[g][1]   = r_done;
        assign w_fld[g][2]   = r_busy;
        assign w_fld[g][3]   = r_last;
        assign w_fld[g][4]   = r_max;
        assign w_fld[g][5]   = r_min;
        assign w_fld[g][6]   = r_stall;
        assign w_fld[g][7]   = {{(CNT_W-3){1'b0}}, r_sat, r_state};
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                w_rd_data = w_fld[c][rd_sel];
                w_rd_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_data  <= '0;
            rd_err   <= 1'b0;
            any_busy <= 1'b0;
        end else begin
            rd_data  <= w_rd_data;
            rd_err   <= w_rd_err;
            any_busy <= |w_busy_vec;
        end
    end

endmodule

// File: tb/tb_ap_handshake_perf_monitor.sv
// Directed bench for ap_handshake_perf_monitor built with 8-bit counters so saturation is reachable.
module tb_ap_handshake_perf_monitor;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
    logic              clear, finish;
    logic [CH_W-1:0]   rd_ch;
    logic [2:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_err, any_busy;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    ap_handshake_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clock(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .clear(clear), .finish(finish),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .rd_err(rd_err), .any_busy(any_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int ch, input int sel, output logic [CNT_W-1:0] d);
        rd_ch  = CH_W'(ch);
        rd_sel = 3'(sel);
        tick();
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [CNT_W-1:0] d, e;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vec++;
        if (rd_data !== 8'd0 || rd_err !== 1'b0 || any_busy !== 1'b0) begin
            miss++;
            $display("FAIL reset_outputs: rd_data=%0d rd_err=%0b any_busy=%0b, expected 0/0/0", rd_data, rd_err, any_busy);
        end
        repeat (10) tick();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 8; s++) begin
                e = (s == 5) ? 8'hFF : 8'h00;
                rd(c, s, d);
                vec++;
                if (d !== e) begin
                    miss++;
                    $display("FAIL reset_ch%0d_sel%0d: got %0d expected %0d", c, s, d, e);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] e [8];
        e = '{8'd1, 8'd1, 8'd4, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0};
        ap_start[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0;
        tick();
        tick();
        vec++;
        if (any_busy !== 1'b1) begin
            miss++;
            $display("FAIL single_any_busy: got %0b expected 1", any_busy);
        end
        tick();
        ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        for (int s = 0; s < 8; s++) begin
            rd(0, s, d);
            vec++;
            if (d !== e[s]) begin
                miss++;
                $display("FAIL single_sel%0d: got %0d expected %0d", s, d, e[s]);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] e [8];
        e = '{8'd3, 8'd3, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
        repeat (3) begin
            ap_start[1] = 1'b1;
            ap_done[1]  = 1'b1;
            tick();
            ap_start[1] = 1'b0;
            ap_done[1]  = 1'b0;
            tick();
        end
        for (int s = 0; s < 8; s++) begin
            rd(1, s, d);
            vec++;
            if (d !== e[s]) begin
                miss++;
                $display("FAIL same_cycle_sel%0d: got %0d expected %0d", s, d, e[s]);
            end
        end
    endtask

    task automatic test_wait_stall();
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] e [8];
        e = '{8'd1, 8'd1, 8'd6, 8'd7, 8'd7, 8'd7, 8'd3, 8'd0};
        ap_continue[2] = 1'b0;
        ap_start[2]    = 1'b1;
        tick();
        ap_start[2] = 1'b0;
        tick();
        tick();
        ap_done[2] = 1'b1;
        tick();
        ap_done[2] = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            if (k == 6) ap_continue[2] = 1'b1;
            rd(2, 7, d);
            vec++;
            if (d !== 8'd2) begin
                miss++;
                $display("FAIL wait_state_cycle%0d: got %0d expected 2", k, d);
            end
        end
        for (int s = 0; s < 8; s++) begin
            rd(2, s, d);
            vec++;
            if (d !== e[s]) begin
                miss++;
                $display("FAIL wait_sel%0d: got %0d expected %0d", s, d, e[s]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] e [8];
        e = '{8'd1, 8'd1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd4};
        ap_start[3] = 1'b1;
        tick();
        ap_start[3] = 1'b0;
        repeat (300) tick();
        ap_done[3] = 1'b1;
        tick();
        ap_done[3] = 1'b0;
        for (int s = 0; s < 8; s++) begin
            rd(3, s, d);
            vec++;
            if (d !== e[s]) begin
                miss++;
                $display("FAIL saturate_sel%0d: got %0d expected %0d", s, d, e[s]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [CNT_W-1:0] d;
        rd(3, 2, d);
        rd(NUM_CH, 0, d);
        vec++;
        if (d !== 8'd0 || rd_err !== 1'b1) begin
            miss++;
            $display("FAIL oor_read: rd_data=%0d rd_err=%0b expected 0/1", d, rd_err);
        end
        rd(0, 0, d);
        vec++;
        if (rd_err !== 1'b0) begin
            miss++;
            $display("FAIL oor_recover: rd_err=%0b expected 0", rd_err);
        end
    endtask

    task automatic test_clear_mid_busy();
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] e [8];
        e = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0};
        ap_start[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0;
        rd(0, 7, d);
        vec++;
        if (d !== 8'd1) begin
            miss++;
            $display("FAIL clear_pre_state: got %0d expected 1", d);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        for (int s = 0; s < 8; s++) begin
            rd(0, s, d);
            vec++;
            if (d !== e[s]) begin
                miss++;
                $display("FAIL clear_ch0_sel%0d: got %0d expected %0d", s, d, e[s]);
            end
        end
        rd(3, 7, d);
        vec++;
        if (d !== 8'd0 || any_busy !== 1'b0) begin
            miss++;
            $display("FAIL clear_ch3_sat: got %0d any_busy=%0b expected 0/0", d, any_busy);
        end
    endtask

    task automatic test_finish();
        logic [CNT_W-1:0] d;
        finish      = 1'b1;
        ap_start[1] = 1'b1;
        tick();
        ap_start[1] = 1'b0;
        rd(1, 5, d);
        vec++;
        if (d !== 8'd255) begin
            miss++;
            $display("FAIL finish_readback: got %0d expected 255", d);
        end
        rd(1, 0, d);
        finish = 1'b0;
        vec++;
        if (d !== 8'd0) begin
            miss++;
            $display("FAIL finish_frozen_start: got %0d expected 0", d);
        end
        rd(1, 7, d);
        vec++;
        if (d !== 8'd0) begin
            miss++;
            $display("FAIL finish_frozen_state: got %0d expected 0", d);
        end
    endtask

    initial begin
        reset       = 1'b1;
        clear       = 1'b0;
        finish      = 1'b0;
        ap_start    = '0;
        ap_ready    = '0;
        ap_done     = '0;
        ap_continue = '1;
        rd_ch       = '0;
        rd_sel      = '0;
        test_reset();
        test_single();
        test_same_cycle();
        test_wait_stall();
        test_saturate();
        test_out_of_range();
        test_clear_mid_busy();
        test_finish();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
